adc_sample_collector: RTL and testbench
=======================================

// Module: adc_sample_collector
// PURPOSE
//  Downstream consumer of adc_control's sample port. Round-robin scans channels MIN_CHANNEL..MAX_CHANNEL.
//  - For each channel: pulses output_sample / channel_select, then captures returned {seq[31:16], sample[15:0]}.
//  - Pushes each newly sequenced sample into a FWFT FIFO drained over a valid/ready port.
//  - Counts FIFO overflows and sequence gaps.
// PARAMETERS
//  MIN_CHANNEL  0  first channel scanned
//  MAX_CHANNEL  1  last channel scanned (<=7, >=MIN_CHANNEL)
//  FIFO_AW      4  FIFO address width; depth = 2**FIFO_AW entries
// PORTS
//  clk             in   1          system clock; the single clock of the block
//  reset           in   1          asynchronous, active-high reset
//  collect_en      in   1          scan enable
//  time_running    in   1          experiment time running; scan only when high
//  clear           in   1          sync clear: FIFO, counters, seq-tracking state
//  output_sample   out  1          sample request to adc_control (registered)
//  channel_select  out  8          channel for request (registered)
//  sample_data     in   32         adc_control reply, valid cycle after request; 0 = no sample
//  current_time    in   32         experiment time base
//  out_data        out  32         FIFO head {seq, sample}
//  out_time        out  32         FIFO head capture time (see CONFIGURATION)
//  out_valid       out  1          FIFO non-empty
//  out_ready       in   1          consumer pops head when out_valid & out_ready
//  fifo_count      out  FIFO_AW+1  occupancy, 0..2**FIFO_AW
//  overflow_count  out  16         samples dropped on full FIFO, saturates at 16'hFFFF
//  gap_count       out  16         sequence discontinuities seen, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, ch=MIN_CHANNEL, FIFO empty, seen[]=0, last_seq[]=0.
//  FSM states:
//  - IDLE: leave to REQ when collect_en & time_running.
//  - REQ (1 cycle): output_sample=1, channel_select=ch. Next state CAPTURE.
//  - CAPTURE (1 cycle): output_sample=0, sample_data evaluated for ch.
//    Next: ch advances (MAX_CHANNEL wraps to MIN_CHANNEL).
//    Next state: REQ if collect_en & time_running still high, else IDLE.
//  - Scan period: 2 cycles/channel. Deasserting enable mid-scan completes the current CAPTURE, then goes IDLE.
//  CAPTURE evaluation, with s = sample_data[31:16]:
//  - sample_data==0: ignored; no state change.
//  - seen[ch] & s==last_seq[ch]: duplicate, ignored.
//  - Otherwise new sample:
//    - if seen[ch] & s != last_seq[ch]+1 (16-bit wrap: FFFF->0000 is contiguous): gap_count++.
//    - last_seq[ch]<=s; seen[ch]<=1.
//    - push {sample_data, time} if not full, else overflow_count++ and sample dropped.
//  FIFO:
//  - First-word-fall-through. out_data/out_time show the head combinationally from storage; 0 when empty.
//  - Pop with out_valid=0 is ignored.
//  - Full with push and pop in the same cycle: both happen, count unchanged, no overflow.
//  - Empty with push and pop in the same cycle: pop ignored, push lands.
//  - fifo_count updates one cycle after the push/pop edge.
//  clear:
//  - Priority over push/pop.
//  - Next cycle: FIFO empty, counters 0, seen[]=0.
//  - FSM continues scanning.
//  Counters saturate; no wrap.
//  reset is asynchronous mid-operation: everything returns to reset values immediately, including output_sample=0.
// CONFIGURATION
//  ADC_COLLECT_TIMESTAMP_EN defined:
//  - FIFO entries 64 bits; current_time sampled in CAPTURE is stored with the sample.
//  - out_time = head timestamp.
//  ADC_COLLECT_TIMESTAMP_EN undefined:
//  - FIFO 32 bits, no time storage.
//  - out_time tied to 32'h0.
// TESTING
//  1 MIN=0,MAX=1, enable both; ch0 replies 0x0001_0ABC then 0x0001_0ABC
//    -> one push 0x00010ABC, fifo_count=1, gap_count=0.
//  2 ch0 replies seq 1,2,5
//    -> 3 pushes, gap_count=1.
//    ch1 replies seq FFFF then 0000 -> no gap.
//  3 out_ready=0, feed 17 distinct samples with FIFO_AW=4
//    -> fifo_count=16, overflow_count=1.
//    Then full + push + pop in same cycle -> count stays 16, overflow stays 1.
//  4 sample_data=0 on every CAPTURE
//    -> no pushes; output_sample pulses 1 of every 2 cycles, channel_select alternates 0,1.
//  5 reset asserted between REQ and CAPTURE
//    -> outputs 0 asynchronously.
//    Deassert, resume -> first sample accepted without gap increment.
//  6 TIMESTAMP_EN on, current_time=0x100 at CAPTURE
//    -> out_time=0x100 with that entry.
//    Macro off -> out_time=0.

Source files
------------

// File: rtl/adc_sample_collector.sv
// adc_sample_collector: round-robin ADC sample poller feeding a FWFT FIFO with overflow and gap counters
// Optional ADC_COLLECT_TIMESTAMP_EN stores current_time alongside each sample.
module adc_sample_collector #(
  parameter int MIN_CHANNEL = 0,
  parameter int MAX_CHANNEL = 1,
  parameter int FIFO_AW     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               collect_en,
  input  logic               time_running,
  input  logic               clear,
  output logic               output_sample,
  output logic [7:0]         channel_select,
  input  logic [31:0]        sample_data,
  input  logic [31:0]        current_time,
  output logic [31:0]        out_data,
  output logic [31:0]        out_time,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIFO_AW:0]   fifo_count,
  output logic [15:0]        overflow_count,
  output logic [15:0]        gap_count
);
  localparam int DEPTH = 2 ** FIFO_AW;
`ifdef ADC_COLLECT_TIMESTAMP_EN
  localparam int DW = 64;
`else
  localparam int DW = 32;
`endif
  typedef enum logic [1:0] {IDLE, REQ, CAPTURE} state_t;
  state_t state, state_n;
  logic [2:0] ch, ch_n;
  logic [7:0] seen;
  logic [15:0] last_seq [8];
  logic [15:0] seq;
  logic run, is_new, gap, pop, full, push, ovf;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] head, entry;
  assign run = collect_en & time_running;
  assign seq = sample_data[31:16];
  always_comb begin
    state_n = state == IDLE ? (run ? REQ : IDLE) : state == REQ ? CAPTURE : (run ? REQ : IDLE);
    ch_n = state == CAPTURE ? (ch == 3'(MAX_CHANNEL) ? 3'(MIN_CHANNEL) : ch + 3'd1) : ch;
    is_new = state == CAPTURE && sample_data != 32'd0 && !(seen[ch] && seq == last_seq[ch]);
    gap = is_new && seen[ch] && seq != last_seq[ch] + 16'd1;
    pop = out_ready & out_valid;
    full = fifo_count == (FIFO_AW+1)'(DEPTH);
    push = is_new & (~full | pop);
    ovf = is_new & full & ~pop;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ch <= 3'(MIN_CHANNEL);
      output_sample <= 1'b0;
      channel_select <= 8'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      overflow_count <= 16'd0;
      gap_count <= 16'd0;
      seen <= 8'd0;
      for (int i = 0; i < 8; i++) last_seq[i] <= 16'd0;
    end else begin
      state <= state_n;
      ch <= ch_n;
      output_sample <= state_n == REQ;
      channel_select <= state_n == REQ ? {5'd0, ch_n} : channel_select;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fifo_count <= '0;
        overflow_count <= 16'd0;
        gap_count <= 16'd0;
        seen <= 8'd0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        fifo_count <= fifo_count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        if (ovf && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
        if (gap && gap_count != 16'hFFFF) gap_count <= gap_count + 16'd1;
        if (is_new) begin
          seen[ch] <= 1'b1;
          last_seq[ch] <= seq;
        end
      end
    end
  end
`ifdef ADC_COLLECT_TIMESTAMP_EN
  assign entry = {current_time, sample_data};
  assign out_time = out_valid ? head[63:32] : 32'h0;
`else
  logic unused_time;
  assign entry = sample_data;
  assign unused_time = ^current_time;
  assign out_time = 32'h0;
`endif
  // storage needs no reset; only occupancy decides what is visible
  always_ff @(posedge clk) if (push && !clear) mem[wr_ptr] <= entry;
  assign head = mem[rd_ptr];
  assign out_valid = fifo_count != '0;
  assign out_data = out_valid ? head[31:0] : 32'h0;
endmodule

// File: tb/tb_adc_sample_collector.sv
// tb_adc_sample_collector: directed checks of scanning, dedupe, gaps, FIFO full/overflow, clear and async reset
module tb_adc_sample_collector;
  logic clk = 0, reset = 1, collect_en = 0, time_running = 0, clear = 0, out_ready = 0;
  logic [31:0] sample_data = 0, current_time = 0;
  logic output_sample, out_valid;
  logic [7:0] channel_select;
  logic [31:0] out_data, out_time;
  logic [4:0] fifo_count;
  logic [15:0] overflow_count, gap_count;
  int total = 0, bad = 0;
  adc_sample_collector #(.MIN_CHANNEL(0), .MAX_CHANNEL(1), .FIFO_AW(4)) dut (
    .clk(clk), .reset(reset), .collect_en(collect_en), .time_running(time_running), .clear(clear),
    .output_sample(output_sample), .channel_select(channel_select), .sample_data(sample_data),
    .current_time(current_time), .out_data(out_data), .out_time(out_time), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count), .overflow_count(overflow_count), .gap_count(gap_count));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  // wait for a request on channel c, reply d in the capture cycle, optionally pop during capture
  task automatic cap(input logic [7:0] c, input logic [31:0] d, input logic p = 0);
    int n = 0;
    while (!(output_sample && channel_select == c) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) chk("req_timeout", 64'(channel_select), 64'(c));
    sample_data = d;
    @(negedge clk);
    out_ready = p;
    @(negedge clk);
    sample_data = 0;
    out_ready = 0;
  endtask
  task automatic do_clear();
    clear = 1;
    @(negedge clk);
    clear = 0;
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_os", 64'(output_sample), 0);
    chk("rst_cs", 64'(channel_select), 0);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_count", 64'(fifo_count), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_gap", 64'(gap_count), 0);
    chk("rst_ovf", 64'(overflow_count), 0);
    reset = 0;
    collect_en = 1;
    time_running = 1;
    @(negedge clk);
    chk("first_req", 64'(output_sample), 1);
    // duplicate suppression
    cap(0, 32'h0001_0ABC);
    cap(0, 32'h0001_0ABC);
    chk("dup_count", 64'(fifo_count), 1);
    chk("dup_data", 64'(out_data), 64'h0001_0ABC);
    chk("dup_gap", 64'(gap_count), 0);
    chk("dup_valid", 64'(out_valid), 1);
    do_clear();
    chk("clr_count", 64'(fifo_count), 0);
    chk("clr_data", 64'(out_data), 0);
    // gap detection and 16-bit wrap
    cap(0, 32'h0001_1111);
    cap(0, 32'h0002_2222);
    cap(0, 32'h0005_5555);
    chk("gap_one", 64'(gap_count), 1);
    cap(1, 32'hFFFF_0001);
    cap(1, 32'h0000_0002);
    chk("wrap_gap", 64'(gap_count), 1);
    chk("wrap_count", 64'(fifo_count), 5);
    chk("head", 64'(out_data), 64'h0001_1111);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("pop_count", 64'(fifo_count), 4);
    chk("pop_head", 64'(out_data), 64'h0002_2222);
    do_clear();
    chk("clr_gap", 64'(gap_count), 0);
    // fill and overflow
    for (int i = 1; i <= 17; i++) cap(0, {16'(i), 16'h00AA});
    chk("full_count", 64'(fifo_count), 16);
    chk("ovf_one", 64'(overflow_count), 1);
    chk("full_gap", 64'(gap_count), 0);
    chk("full_head", 64'(out_data), 64'h0001_00AA);
    cap(0, 32'h0012_00AA, 1);
    chk("pp_count", 64'(fifo_count), 16);
    chk("pp_ovf", 64'(overflow_count), 1);
    chk("pp_head", 64'(out_data), 64'h0002_00AA);
    do_clear();
    chk("clr_ovf", 64'(overflow_count), 0);
    // idle replies: request pattern only
    cap(0, 0);
    for (int i = 0; i < 6; i++) begin
      chk("pat_os", 64'(output_sample), 64'(i % 2 == 0));
      if (i % 2 == 0) chk("pat_cs", 64'(channel_select), 64'((i / 2) % 2 == 0));
      @(negedge clk);
    end
    chk("pat_count", 64'(fifo_count), 0);
    // async reset between request and capture
    cap(0, 32'h0010_0001);
    chk("pre_rst_count", 64'(fifo_count), 1);
    while (!output_sample) @(negedge clk);
    reset = 1;
    #1;
    chk("arst_os", 64'(output_sample), 0);
    chk("arst_cs", 64'(channel_select), 0);
    chk("arst_count", 64'(fifo_count), 0);
    @(negedge clk);
    reset = 0;
    current_time = 32'h100;
    cap(0, 32'h0050_0001);
    chk("post_rst_gap", 64'(gap_count), 0);
    chk("post_rst_count", 64'(fifo_count), 1);
    chk("post_rst_data", 64'(out_data), 64'h0050_0001);
`ifdef ADC_COLLECT_TIMESTAMP_EN
    chk("out_time", 64'(out_time), 64'h100);
`else
    chk("out_time", 64'(out_time), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
